// File: rtl/wash_pkg.sv
// Shared types and constants for the washing-machine program sequencer:
// stage encoding, per-program stage durations and totals, and lamp patterns.
package wash_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WASH  = 3'd2,
        DRAIN = 3'd3,
        SPIN  = 3'd4,
        DONE  = 3'd5
    } stage_e;

    // Program selector values
    localparam logic [1:0] MODE_QUICK  = 2'd0;
    localparam logic [1:0] MODE_NORMAL = 2'd1;
    localparam logic [1:0] MODE_HEAVY  = 2'd2;
    localparam logic [1:0] MODE_SPIN   = 2'd3;

    // Stage durations in seconds (FILL / WASH / DRAIN / SPIN)
    localparam logic [5:0] QUICK_FILL   = 6'd5;
    localparam logic [5:0] QUICK_WASH   = 6'd10;
    localparam logic [5:0] QUICK_DRAIN  = 6'd5;
    localparam logic [5:0] QUICK_SPIN   = 6'd10;

    localparam logic [5:0] NORMAL_FILL  = 6'd10;
    localparam logic [5:0] NORMAL_WASH  = 6'd40;
    localparam logic [5:0] NORMAL_DRAIN = 6'd10;
    localparam logic [5:0] NORMAL_SPIN  = 6'd20;

    localparam logic [5:0] HEAVY_FILL   = 6'd15;
    localparam logic [5:0] HEAVY_WASH   = 6'd50;
    localparam logic [5:0] HEAVY_DRAIN  = 6'd15;
    localparam logic [5:0] HEAVY_SPIN   = 6'd19;

    localparam logic [5:0] SPINONLY_FILL  = 6'd0;
    localparam logic [5:0] SPINONLY_WASH  = 6'd0;
    localparam logic [5:0] SPINONLY_DRAIN = 6'd5;
    localparam logic [5:0] SPINONLY_SPIN  = 6'd15;

    // Program totals; each equals the sum of its four stage durations
    localparam logic [6:0] QUICK_TOTAL    = 7'd30;
    localparam logic [6:0] NORMAL_TOTAL   = 7'd80;
    localparam logic [6:0] HEAVY_TOTAL    = 7'd99;
    localparam logic [6:0] SPINONLY_TOTAL = 7'd20;

    // Stage lamp patterns (bit 7 additionally shows the pause flag)
    localparam logic [7:0] LIGHT_IDLE  = 8'h00;
    localparam logic [7:0] LIGHT_FILL  = 8'h01;
    localparam logic [7:0] LIGHT_WASH  = 8'h03;
    localparam logic [7:0] LIGHT_DRAIN = 8'h07;
    localparam logic [7:0] LIGHT_SPIN  = 8'h0F;
    localparam logic [7:0] LIGHT_DONE  = 8'hFF;

    // True for the stages in which the machine is working a program
    function automatic logic isActive(input stage_e s);
        return (s == FILL) || (s == WASH) || (s == DRAIN) || (s == SPIN);
    endfunction

    // Duration of one stage of one program; non-working stages have none
    function automatic logic [5:0] stageDuration(input logic [1:0] m, input stage_e s);
        logic [5:0] d;
        d = 6'd0;
        case (m)
            MODE_QUICK: begin
                case (s)
                    FILL:    d = QUICK_FILL;
                    WASH:    d = QUICK_WASH;
                    DRAIN:   d = QUICK_DRAIN;
                    SPIN:    d = QUICK_SPIN;
                    default: d = 6'd0;
                endcase
            end
            MODE_NORMAL: begin
                case (s)
                    FILL:    d = NORMAL_FILL;
                    WASH:    d = NORMAL_WASH;
                    DRAIN:   d = NORMAL_DRAIN;
                    SPIN:    d = NORMAL_SPIN;
                    default: d = 6'd0;
                endcase
            end
            MODE_HEAVY: begin
                case (s)
                    FILL:    d = HEAVY_FILL;
                    WASH:    d = HEAVY_WASH;
                    DRAIN:   d = HEAVY_DRAIN;
                    SPIN:    d = HEAVY_SPIN;
                    default: d = 6'd0;
                endcase
            end
            default: begin
                case (s)
                    FILL:    d = SPINONLY_FILL;
                    WASH:    d = SPINONLY_WASH;
                    DRAIN:   d = SPINONLY_DRAIN;
                    SPIN:    d = SPINONLY_SPIN;
                    default: d = 6'd0;
                endcase
            end
        endcase
        return d;
    endfunction

    // Total program length, loaded into the seconds-remaining display on start
    function automatic logic [6:0] programTotal(input logic [1:0] m);
        logic [6:0] t;
        case (m)
            MODE_QUICK:  t = QUICK_TOTAL;
            MODE_NORMAL: t = NORMAL_TOTAL;
            MODE_HEAVY:  t = HEAVY_TOTAL;
            default:     t = SPINONLY_TOTAL;
        endcase
        return t;
    endfunction

    // First working stage at or after 's' with a nonzero duration; DONE if none.
    // Scanned from the back so the earliest qualifying stage wins.
    function automatic stage_e firstStageFrom(input logic [1:0] m, input stage_e s);
        stage_e r;
        r = DONE;
        if ((s <= SPIN)  && (stageDuration(m, SPIN)  != 6'd0)) r = SPIN;
        if ((s <= DRAIN) && (stageDuration(m, DRAIN) != 6'd0)) r = DRAIN;
        if ((s <= WASH)  && (stageDuration(m, WASH)  != 6'd0)) r = WASH;
        if ((s <= FILL)  && (stageDuration(m, FILL)  != 6'd0)) r = FILL;
        return r;
    endfunction

    // Stage that follows 's' in program order (SPIN is followed by DONE)
    function automatic stage_e followingStage(input stage_e s);
        stage_e r;
        case (s)
            FILL:    r = WASH;
            WASH:    r = DRAIN;
            DRAIN:   r = SPIN;
            default: r = DONE;
        endcase
        return r;
    endfunction

    // Lamp pattern for a stage, before the pause bit is merged in
    function automatic logic [7:0] lightPattern(input stage_e s);
        logic [7:0] p;
        case (s)
            FILL:    p = LIGHT_FILL;
            WASH:    p = LIGHT_WASH;
            DRAIN:   p = LIGHT_DRAIN;
            SPIN:    p = LIGHT_SPIN;
            DONE:    p = LIGHT_DONE;
            default: p = LIGHT_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/wash_sequencer_tick_gen.sv
// One-second prescaler: counts enabled clock cycles and pulses 'tick' on the
// last cycle of each TICK_DIV-cycle period. Holds its count while disabled.
module tick_gen #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count and tick pulse; clear wins over counting
    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (count_q == LAST) begin
                count_d = '0;
                tick    = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: walks FILL -> WASH -> DRAIN -> SPIN with
// per-program durations, handles pause and door-open, and publishes the
// remaining seconds (binary and BCD), actuator enables and stage lamps.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic [1:0] mode,
    input  logic       door_closed,
    output logic [2:0] stage,
    output logic [6:0] secs_left,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       valve,
    output logic       motor,
    output logic       drain,
    output logic       door_lock,
    output logic       done,
    output logic       paused,
    output logic [7:0] st_light
);

    stage_e     stage_q,  stage_d;
    logic [6:0] secs_q,   secs_d;
    logic [5:0] cnt_q,    cnt_d;
    logic [1:0] mode_q,   mode_d;
    logic       paused_q, paused_d;
    logic       forced_q, forced_d;

    logic [3:0] tens_q;
    logic [3:0] ones_q;
    logic       valve_q;
    logic       motor_q;
    logic       drain_q;
    logic       lock_q;
    logic       done_q;
    logic [7:0] light_q;

    logic startAccept;
    logic tickEn;
    logic tick;

    // Seconds only elapse while a program is running and not paused
    assign tickEn = isActive(stage_q) && !paused_q;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (tickEn),
        .clr (startAccept),
        .tick(tick)
    );

    // Next-state: start acceptance, per-second countdown with stage advance,
    // then pause/door handling layered on top so a same-cycle tick still lands
    always_comb begin
        stage_d     = stage_q;
        secs_d      = secs_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        paused_d    = paused_q;
        forced_d    = forced_q;
        startAccept = 1'b0;

        if (((stage_q == IDLE) || (stage_q == DONE)) && start && door_closed) begin
            startAccept = 1'b1;
            mode_d      = mode;
            stage_d     = firstStageFrom(mode, FILL);
            secs_d      = programTotal(mode);
            cnt_d       = stageDuration(mode, firstStageFrom(mode, FILL));
            paused_d    = 1'b0;
            forced_d    = 1'b0;
        end else if (isActive(stage_q)) begin
            if (tick) begin
                secs_d = (secs_q == 7'd0) ? 7'd0 : (secs_q - 7'd1);
                if (cnt_q <= 6'd1) begin
                    stage_d = firstStageFrom(mode_q, followingStage(stage_q));
                    cnt_d   = stageDuration(mode_q, stage_d);
                    if (stage_d == DONE) begin
                        secs_d = 7'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end

            if (pause) begin
                if (!paused_q) begin
                    paused_d = 1'b1;
                end else if (door_closed) begin
                    paused_d = 1'b0;
                    forced_d = 1'b0;
                end
            end

            if (!door_closed) begin
                paused_d = 1'b1;
                forced_d = 1'b1;
            end

            if (stage_d == DONE) begin
                paused_d = 1'b0;
                forced_d = 1'b0;
            end
        end
    end

    // State and registered outputs, all derived from the next-state values
    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_q  <= IDLE;
            secs_q   <= 7'd0;
            cnt_q    <= 6'd0;
            mode_q   <= 2'd0;
            paused_q <= 1'b0;
            forced_q <= 1'b0;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            valve_q  <= 1'b0;
            motor_q  <= 1'b0;
            drain_q  <= 1'b0;
            lock_q   <= 1'b0;
            done_q   <= 1'b0;
            light_q  <= 8'h00;
        end else begin
            stage_q  <= stage_d;
            secs_q   <= secs_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            paused_q <= paused_d;
            forced_q <= forced_d;
            tens_q   <= 4'(secs_d / 7'd10);
            ones_q   <= 4'(secs_d % 7'd10);
            valve_q  <= (stage_d == FILL) && !paused_d;
            motor_q  <= ((stage_d == WASH) || (stage_d == SPIN)) && !paused_d;
            drain_q  <= ((stage_d == DRAIN) || (stage_d == SPIN)) && !paused_d;
            lock_q   <= isActive(stage_d) && !forced_d;
            done_q   <= (stage_d == DONE);
            light_q  <= lightPattern(stage_d) | {paused_d, 7'b0};
        end
    end

    assign stage     = stage_q;
    assign secs_left = secs_q;
    assign bcd_tens  = tens_q;
    assign bcd_ones  = ones_q;
    assign valve     = valve_q;
    assign motor     = motor_q;
    assign drain     = drain_q;
    assign door_lock = lock_q;
    assign done      = done_q;
    assign paused    = paused_q;
    assign st_light  = light_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer with a scoreboard of expected outputs.
module tb_wash_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       pause;
    logic [1:0] mode;
    logic       door_closed;
    logic [2:0] stage;
    logic [6:0] secs_left;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       valve;
    logic       motor;
    logic       drain;
    logic       door_lock;
    logic       done;
    logic       paused;
    logic [7:0] st_light;

    int checks = 0;
    int errors = 0;

    localparam int F_STAGE  = 0;
    localparam int F_SECS   = 1;
    localparam int F_TENS   = 2;
    localparam int F_ONES   = 3;
    localparam int F_VALVE  = 4;
    localparam int F_MOTOR  = 5;
    localparam int F_DRAIN  = 6;
    localparam int F_LOCK   = 7;
    localparam int F_DONE   = 8;
    localparam int F_PAUSED = 9;
    localparam int F_LIGHT  = 10;

    localparam logic [7:0] S_IDLE  = 8'd0;
    localparam logic [7:0] S_FILL  = 8'd1;
    localparam logic [7:0] S_WASH  = 8'd2;
    localparam logic [7:0] S_DRAIN = 8'd3;
    localparam logic [7:0] S_SPIN  = 8'd4;
    localparam logic [7:0] S_DONE  = 8'd5;

    typedef struct {
        int         field;
        logic [7:0] value;
        string      tag;
    } exp_t;

    exp_t sb[$];

    wash_sequencer #(
        .TICK_DIV(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .mode       (mode),
        .door_closed(door_closed),
        .stage      (stage),
        .secs_left  (secs_left),
        .bcd_tens   (bcd_tens),
        .bcd_ones   (bcd_ones),
        .valve      (valve),
        .motor      (motor),
        .drain      (drain),
        .door_lock  (door_lock),
        .done       (done),
        .paused     (paused),
        .st_light   (st_light)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] observe(input int f);
        logic [7:0] v;
        case (f)
            F_STAGE:  v = {5'd0, stage};
            F_SECS:   v = {1'b0, secs_left};
            F_TENS:   v = {4'd0, bcd_tens};
            F_ONES:   v = {4'd0, bcd_ones};
            F_VALVE:  v = {7'd0, valve};
            F_MOTOR:  v = {7'd0, motor};
            F_DRAIN:  v = {7'd0, drain};
            F_LOCK:   v = {7'd0, door_lock};
            F_DONE:   v = {7'd0, done};
            F_PAUSED: v = {7'd0, paused};
            default:  v = st_light;
        endcase
        return v;
    endfunction

    task automatic expectOut(input int f, input logic [7:0] value, input string tag);
        exp_t e;
        e.field = f;
        e.value = value;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t       e;
        logic [7:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.field);
            checks++;
            assert (obs === e.value) else begin
                errors++;
                $display("[TB] FAIL %s: observed %0h expected %0h", e.tag, obs, e.value);
                $error("[TB] assertion error on %s", e.tag);
            end
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one cycle of inputs; start/pause are pulses, door level persists
    task automatic applyStimulus(input logic s, input logic p, input logic [1:0] m, input logic d);
        start       = s;
        pause       = p;
        mode        = m;
        door_closed = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic applyReset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst         = 1'b0;
        start       = 1'b0;
        pause       = 1'b0;
        mode        = 2'd0;
        door_closed = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state
        expectOut(F_STAGE, S_IDLE, "rst_stage");
        expectOut(F_SECS, 8'd0, "rst_secs");
        expectOut(F_TENS, 8'd0, "rst_tens");
        expectOut(F_ONES, 8'd0, "rst_ones");
        expectOut(F_VALVE, 8'd0, "rst_valve");
        expectOut(F_MOTOR, 8'd0, "rst_motor");
        expectOut(F_DRAIN, 8'd0, "rst_drain");
        expectOut(F_LOCK, 8'd0, "rst_lock");
        expectOut(F_DONE, 8'd0, "rst_done");
        expectOut(F_PAUSED, 8'd0, "rst_paused");
        expectOut(F_LIGHT, 8'h00, "rst_light");
        checkOutput();

        // Quick program, full run
        expectOut(F_STAGE, S_FILL, "m0_fill");
        expectOut(F_SECS, 8'd30, "m0_secs30");
        expectOut(F_TENS, 8'd3, "m0_tens3");
        expectOut(F_ONES, 8'd0, "m0_ones0");
        expectOut(F_VALVE, 8'd1, "m0_valve");
        expectOut(F_LOCK, 8'd1, "m0_lock");
        expectOut(F_LIGHT, 8'h01, "m0_light_fill");
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b1);
        checkOutput();

        expectOut(F_STAGE, S_FILL, "m0_still_fill");
        expectOut(F_SECS, 8'd26, "m0_secs26");
        waitCycles(19);
        checkOutput();

        expectOut(F_STAGE, S_WASH, "m0_wash");
        expectOut(F_SECS, 8'd25, "m0_secs25");
        expectOut(F_MOTOR, 8'd1, "m0_wash_motor");
        expectOut(F_VALVE, 8'd0, "m0_wash_valve");
        expectOut(F_LIGHT, 8'h03, "m0_light_wash");
        waitCycles(1);
        checkOutput();

        expectOut(F_STAGE, S_DRAIN, "m0_drain");
        expectOut(F_SECS, 8'd15, "m0_secs15");
        expectOut(F_DRAIN, 8'd1, "m0_drain_drain");
        expectOut(F_MOTOR, 8'd0, "m0_drain_motor");
        waitCycles(40);
        checkOutput();

        expectOut(F_STAGE, S_SPIN, "m0_spin");
        expectOut(F_SECS, 8'd10, "m0_secs10");
        expectOut(F_MOTOR, 8'd1, "m0_spin_motor");
        expectOut(F_DRAIN, 8'd1, "m0_spin_drain");
        expectOut(F_LIGHT, 8'h0F, "m0_light_spin");
        waitCycles(20);
        checkOutput();

        expectOut(F_STAGE, S_DONE, "m0_done_stage");
        expectOut(F_SECS, 8'd0, "m0_done_secs");
        expectOut(F_DONE, 8'd1, "m0_done_flag");
        expectOut(F_LIGHT, 8'hFF, "m0_done_light");
        expectOut(F_TENS, 8'd0, "m0_done_tens");
        expectOut(F_ONES, 8'd0, "m0_done_ones");
        expectOut(F_LOCK, 8'd0, "m0_done_lock");
        expectOut(F_MOTOR, 8'd0, "m0_done_motor");
        waitCycles(40);
        checkOutput();

        // Spin-only program skips FILL and WASH, restarted from DONE
        expectOut(F_STAGE, S_DRAIN, "m3_drain");
        expectOut(F_SECS, 8'd20, "m3_secs20");
        expectOut(F_DRAIN, 8'd1, "m3_drain_on");
        expectOut(F_VALVE, 8'd0, "m3_valve_off");
        expectOut(F_DONE, 8'd0, "m3_done_clr");
        expectOut(F_TENS, 8'd2, "m3_tens2");
        expectOut(F_LIGHT, 8'h07, "m3_light");
        applyStimulus(1'b1, 1'b0, 2'd3, 1'b1);
        checkOutput();

        // Start while running is ignored
        waitCycles(5);
        expectOut(F_STAGE, S_DRAIN, "run_start_stage");
        expectOut(F_SECS, 8'd19, "run_start_secs");
        expectOut(F_TENS, 8'd1, "run_start_tens");
        expectOut(F_ONES, 8'd9, "run_start_ones");
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b1);
        checkOutput();

        expectOut(F_STAGE, S_SPIN, "m3_spin");
        expectOut(F_SECS, 8'd15, "m3_secs15");
        waitCycles(14);
        checkOutput();

        // Reset mid-SPIN
        expectOut(F_STAGE, S_IDLE, "mid_rst_stage");
        expectOut(F_SECS, 8'd0, "mid_rst_secs");
        expectOut(F_MOTOR, 8'd0, "mid_rst_motor");
        expectOut(F_DRAIN, 8'd0, "mid_rst_drain");
        expectOut(F_LOCK, 8'd0, "mid_rst_lock");
        expectOut(F_PAUSED, 8'd0, "mid_rst_paused");
        expectOut(F_LIGHT, 8'h00, "mid_rst_light");
        applyReset();
        checkOutput();

        // Heavy program: BCD 99 then 98 after one tick
        expectOut(F_STAGE, S_FILL, "m2_fill");
        expectOut(F_TENS, 8'd9, "m2_tens9");
        expectOut(F_ONES, 8'd9, "m2_ones9");
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b1);
        checkOutput();

        expectOut(F_SECS, 8'd98, "m2_secs98");
        expectOut(F_TENS, 8'd9, "m2_tick_tens");
        expectOut(F_ONES, 8'd8, "m2_tick_ones");
        expectOut(F_VALVE, 8'd1, "m2_valve");
        waitCycles(4);
        checkOutput();

        expectOut(F_STAGE, S_WASH, "m2_wash");
        expectOut(F_SECS, 8'd84, "m2_secs84");
        waitCycles(56);
        checkOutput();

        // Pause in WASH: prescaler sits at 2 before the pause edge
        waitCycles(2);
        expectOut(F_PAUSED, 8'd1, "pause_flag");
        expectOut(F_MOTOR, 8'd0, "pause_motor");
        expectOut(F_LIGHT, 8'h83, "pause_light");
        expectOut(F_LOCK, 8'd1, "pause_lock");
        expectOut(F_SECS, 8'd84, "pause_secs");
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b1);
        checkOutput();

        expectOut(F_SECS, 8'd84, "pause_frozen");
        expectOut(F_PAUSED, 8'd1, "pause_held");
        waitCycles(40);
        checkOutput();

        expectOut(F_PAUSED, 8'd0, "resume_flag");
        expectOut(F_MOTOR, 8'd1, "resume_motor");
        expectOut(F_SECS, 8'd84, "resume_secs");
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b1);
        checkOutput();

        // Retained prescaler value means the tick arrives one cycle later
        expectOut(F_SECS, 8'd83, "resume_tick");
        waitCycles(1);
        checkOutput();

        // Door opened mid-run forces pause and releases the lock
        expectOut(F_PAUSED, 8'd1, "door_force");
        expectOut(F_LOCK, 8'd0, "door_unlock");
        expectOut(F_MOTOR, 8'd0, "door_motor");
        expectOut(F_LIGHT, 8'h83, "door_light");
        applyStimulus(1'b0, 1'b0, 2'd2, 1'b0);
        checkOutput();

        expectOut(F_PAUSED, 8'd1, "door_open_resume");
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b0);
        checkOutput();

        expectOut(F_PAUSED, 8'd1, "door_closed_still");
        expectOut(F_LOCK, 8'd0, "door_closed_lock");
        applyStimulus(1'b0, 1'b0, 2'd2, 1'b1);
        checkOutput();

        expectOut(F_PAUSED, 8'd0, "door_resume");
        expectOut(F_MOTOR, 8'd1, "door_resume_motor");
        expectOut(F_LOCK, 8'd1, "door_resume_lock");
        expectOut(F_SECS, 8'd83, "door_resume_secs");
        expectOut(F_STAGE, S_WASH, "door_resume_stage");
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b1);
        checkOutput();

        // From IDLE: start with door open and pause are ignored
        applyReset();
        expectOut(F_STAGE, S_IDLE, "open_start_stage");
        expectOut(F_SECS, 8'd0, "open_start_secs");
        applyStimulus(1'b1, 1'b0, 2'd1, 1'b0);
        checkOutput();

        expectOut(F_PAUSED, 8'd0, "idle_pause");
        expectOut(F_STAGE, S_IDLE, "idle_pause_stage");
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b1);
        checkOutput();

        // Normal program start
        expectOut(F_STAGE, S_FILL, "m1_fill");
        expectOut(F_SECS, 8'd80, "m1_secs80");
        expectOut(F_TENS, 8'd8, "m1_tens8");
        expectOut(F_ONES, 8'd0, "m1_ones0");
        applyStimulus(1'b1, 1'b0, 2'd1, 1'b1);
        checkOutput();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Program sequencer for the washing-machine controller. Takes start/pause requests and a program selector, steps the machine through FILL → WASH → DRAIN → SPIN with per-program durations, and drives the actuator enables and door lock. It also publishes the total seconds remaining, as binary and BCD, for the 4-digit display scanner, plus the stage lamp pattern.

## Interface
- `TICK_DIV`, default 100_000_000: clk cycles per one-second tick; benches use 4.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse that starts the selected program.
- `pause` in 1: one-cycle pulse that toggles pause/resume.
- `mode` in 2: program select, sampled only on an accepted `start`.
- `door_closed` in 1: door switch, 1 = closed.
- `stage` out 3: current state encoding from `wash_pkg`.
- `secs_left` out 7: total seconds remaining, 0..99.
- `bcd_tens`, `bcd_ones` out 4 each: BCD of `secs_left`.
- `valve`, `motor`, `drain`, `door_lock`, `done`, `paused` out 1 each.
- `st_light` out 8: stage lamps.

## Operation
- States: IDLE, FILL, WASH, DRAIN, SPIN, DONE. `paused` is a flag and is not a separate state.
- Durations in seconds, in FILL/WASH/DRAIN/SPIN order:
  - mode 0 (quick): 5/10/5/10, total 30.
  - mode 1 (normal): 10/40/10/20, total 80.
  - mode 2 (heavy): 15/50/15/19, total 99.
  - mode 3 (spin-only): 0/0/5/15, total 20.
  - A stage with duration 0 is skipped with no cycle spent in it.
- Accepted `start` requires `stage` ∈ {IDLE, DONE} and `door_closed`=1. On accept:
  - load `secs_left` with the program total;
  - load the stage counter with the first nonzero duration and enter that stage;
  - clear the prescaler, `paused` and `done`.
- `start` in any other state is ignored.
- On each tick while running and not paused:
  - decrement `secs_left` and the stage counter by 1;
  - if the stage counter was 1, advance to the next nonzero stage and load its duration;
  - after SPIN, go to DONE with `secs_left`=0.
- Pause:
  - A `pause` pulse in an active stage toggles `paused`. It is ignored in IDLE and DONE.
  - `door_closed`=0 in an active stage forces `paused`=1.
  - A resume pulse while the door is open is ignored.
- Outputs:
  - `valve`=FILL. `motor`=WASH|SPIN. `drain`=DRAIN|SPIN. All three are forced to 0 while paused.
  - `door_lock`=1 in any active stage, including while paused, except after a door-open force.
  - `done`=1 only in DONE.
- `st_light` by stage:
  - IDLE 8'h00, FILL 8'h01, WASH 8'h03, DRAIN 8'h07, SPIN 8'h0F, DONE 8'hFF.
  - Bit 7 is OR'd with `paused`.
- Arithmetic:
  - `secs_left` never underflows; it saturates at 0.
  - BCD tens = `secs_left`/10 and ones = `secs_left`%10. Both are registered alongside `secs_left`.

## Timing
- Reset values: `stage`=IDLE, `secs_left`=0, BCD=0/0, every flag=0, `st_light`=0, prescaler=0.
- All outputs are registered. Response to `start`, `pause` or the door is visible 1 cycle later.
- Prescaler counts only while running and unpaused. It holds its value while paused.
- Tick fires when the prescaler equals `TICK_DIV`-1, so the first tick comes `TICK_DIV` cycles after the start is accepted.
- Tick and `pause` in the same cycle: the tick is applied, then `paused` sets.
- Tick and door-open in the same cycle: the tick is applied, then the force-pause.
- Stage advance and `secs_left` decrement occur in the same cycle. There are no idle cycles between stages.
- Reset mid-program returns to IDLE immediately. All actuators go to 0 in the cycle after the `rst` sample.

## Structure
- `wash_pkg` contains:
  - the state enum;
  - the per-mode duration constants and totals;
  - the `st_light` patterns.
- Sub-module `tick_gen`: prescaler with `en` and `clr` inputs and a `tick` output.
- The BCD split stays inline.

## Test plan
- Mode 0, `TICK_DIV`=4, `start` → FILL with `secs_left`=30. WASH after 20 cycles, DRAIN at 60, SPIN at 80, DONE at 120 with `done`=1, `st_light`=8'hFF, BCD 0/0.
- Mode 3 `start` → goes straight to DRAIN with `secs_left`=20, `drain`=1, `valve`=0.
- Mode 2 `start` → BCD 9/9. After 1 tick BCD is 9/8, `valve`=1.
- In WASH, `pause` pulse:
  - `motor`=0, `paused`=1, `st_light`=8'h83, `secs_left` frozen for 40 cycles;
  - a second `pause` resumes with the prescaler value retained.
- During a run, drop `door_closed` → `paused`=1. A `pause` pulse with the door still open leaves `paused`=1. Close the door, then `pause` → resumes.
- Mid-SPIN, assert `rst` low for 1 cycle → IDLE, `secs_left`=0, all flags 0. A `start` while running is ignored, and `secs_left` is unchanged.
